// File: rtl/tog_pulse_rx.sv
// -----------------------------------------------------------------------------
// tog_pulse_rx
// Receive side of a toggle-event crossing. The sender flips tog_in once per
// event. This block synchronizes that level into the clk domain and detects
// each level change. Every change is presented as one event on a
// valid/ready handshake.
//
// Parameters
//   SYNC_STAGES : synchronizer depth, legal range 2..4
//   CNT_W       : width of evt_count
//
// Ports
//   clk        in   destination-domain clock
//   rst        in   synchronous, active-high reset
//   tog_in     in   asynchronous toggle level from the sender
//   evt_valid  out  event pending for downstream (registered)
//   evt_ready  in   downstream accepts when evt_valid is also high
//   evt_count  out  detected level changes, modulo 2^CNT_W
//   overrun    out  sticky: an event arrived while one was still pending
//   clr_ovr    in   clears overrun (a simultaneous new drop wins)
//   level      out  synchronized tog_in (last synchronizer stage)
//   tog_ack    out  acknowledge toggle back to the sender
//
// Build option
//   TOG_RX_ACK_EN : when defined, tog_ack is a flop that inverts on every
//                   accepted handshake. When undefined, tog_ack is tied to 0.
//
// Sender constraint: tog_in must hold each level for at least 2 clk periods.
// If it toggles faster, the changes can merge, and merged toggles are lost
// silently.
// -----------------------------------------------------------------------------
module tog_pulse_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tog_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_count,
    output logic             overrun,
    input  logic             clr_ovr,
    output logic             level,
    output logic             tog_ack
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    // Priming lasts SYNC_STAGES+1 cycles. The counter runs 0..SYNC_STAGES.
    localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic [2:0]             prime_cnt_r;
    logic                   armed_r;
    logic                   edge_s;
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   valid_nxt_s;
    logic                   drop_s;
    logic                   evt_valid_r;
    logic [CNT_W-1:0]       evt_count_r;
    logic                   overrun_r;

    assign level = sync_r[SYNC_STAGES-1];

    // Level changes count only after priming. This keeps a tog_in that is
    // held high through reset from producing a spurious event.
    assign edge_s = armed_r & (level ^ prev_r);

    // Synchronizer chain for the asynchronous toggle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], tog_in};
        end
    end

    // Previous synchronized level, used for change detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= level;
        end
    end

    // Priming counter. Arms edge detection once the chain has settled.
    always_ff @(posedge clk) begin
        if (rst) begin
            prime_cnt_r <= 3'd0;
            armed_r     <= 1'b0;
        end else if (!armed_r) begin
            if (prime_cnt_r == PRIME_LAST) begin
                armed_r <= 1'b1;
            end else begin
                prime_cnt_r <= prime_cnt_r + 3'd1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic. An edge together with an accept keeps PEND,
    // so back-to-back events see no bubble.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (edge_s) begin
                    state_nxt_s = PEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PEND: begin
                if (evt_ready && !edge_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = PEND;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output decode. Produces the next evt_valid and the drop condition.
    always_comb begin
        valid_nxt_s = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                valid_nxt_s = edge_s;
                drop_s      = 1'b0;
            end
            PEND: begin
                valid_nxt_s = (state_nxt_s == PEND);
                drop_s      = edge_s & ~evt_ready;
            end
            default: begin
                valid_nxt_s = 1'b0;
                drop_s      = 1'b0;
            end
        endcase
    end

    // Registered evt_valid. It is high exactly while the FSM is in PEND.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid_r <= 1'b0;
        end else begin
            evt_valid_r <= valid_nxt_s;
        end
    end

    // Event counter. It counts every detected change, dropped ones included,
    // and wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_count_r <= {CNT_W{1'b0}};
        end else if (edge_s) begin
            evt_count_r <= evt_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Sticky overrun flag. Setting takes priority over clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (clr_ovr) begin
            overrun_r <= 1'b0;
        end
    end

    assign evt_valid = evt_valid_r;
    assign evt_count = evt_count_r;
    assign overrun   = overrun_r;

`ifdef TOG_RX_ACK_EN
    logic accept_s;
    logic tog_ack_r;

    assign accept_s = evt_valid_r & evt_ready;

    // Two-phase acknowledge. It inverts on each accepted handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            tog_ack_r <= 1'b0;
        end else if (accept_s) begin
            tog_ack_r <= ~tog_ack_r;
        end
    end

    assign tog_ack = tog_ack_r;
`else
    assign tog_ack = 1'b0;
`endif

endmodule

// File: tb/tb_tog_pulse_rx.sv
// -----------------------------------------------------------------------------
// tb_tog_pulse_rx
// Directed bench for tog_pulse_rx with SYNC_STAGES=2 and CNT_W=8.
// Inputs are driven 1 ns after each rising edge. Outputs are sampled at the
// same point, where they are stable.
// -----------------------------------------------------------------------------
module tb_tog_pulse_rx;

`ifdef TOG_RX_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tog_in;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_count;
    logic       overrun;
    logic       clr_ovr;
    logic       level;
    logic       tog_ack;

    int   errors = 0;
    int   checks = 0;
    logic ack_par;
    int   hs;

    tog_pulse_rx #(.SYNC_STAGES(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .tog_in    (tog_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_count (evt_count),
        .overrun   (overrun),
        .clr_ovr   (clr_ovr),
        .level     (level),
        .tog_ack   (tog_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ack_exp(input logic par);
        return ACK_EN ? par : 1'b0;
    endfunction

    task automatic do_reset(input logic t);
        rst     = 1'b1;
        tog_in  = t;
        clr_ovr = 1'b0;
        ack_par = 1'b0;
        step();
        step();
        rst = 1'b0;
        repeat (6) step();
    endtask

    initial begin
        rst       = 1'b1;
        tog_in    = 1'b0;
        evt_ready = 1'b1;
        clr_ovr   = 1'b0;
        ack_par   = 1'b0;

        // Test 1: reset state, single event latency and one-cycle pulse.
        step();
        step();
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_count", 32'(evt_count), 32'd0);
        check("rst_ovr",   32'(overrun),   32'd0);
        check("rst_ack",   32'(tog_ack),   32'd0);
        check("rst_level", 32'(level),     32'd0);
        rst = 1'b0;
        repeat (8) step();
        tog_in = 1'b1;
        step();
        check("t1_lat_k",  32'(evt_valid), 32'd0);
        step();
        check("t1_lat_k1", 32'(evt_valid), 32'd0);
        step();
        check("t1_valid",  32'(evt_valid), 32'd1);
        check("t1_count",  32'(evt_count), 32'd1);
        check("t1_ovr",    32'(overrun),   32'd0);
        step();
        ack_par = ~ack_par;
        check("t1_pulse1", 32'(evt_valid), 32'd0);
        check("t1_ack",    32'(tog_ack),   32'(ack_exp(ack_par)));

        // Test 2: tog_in held high through reset and priming gives no event.
        rst     = 1'b1;
        tog_in  = 1'b1;
        ack_par = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t2_prime_valid", 32'(evt_valid), 32'd0);
        end
        check("t2_count0", 32'(evt_count), 32'd0);
        check("t2_level",  32'(level),     32'd1);
        tog_in = 1'b0;
        step();
        step();
        step();
        check("t2_valid", 32'(evt_valid), 32'd1);
        check("t2_count", 32'(evt_count), 32'd1);
        step();
        check("t2_once", 32'(evt_valid), 32'd0);
        step();
        step();
        check("t2_quiet", 32'(evt_valid), 32'd0);

        // Test 3: with ready low, a second toggle is dropped and flags overrun.
        evt_ready = 1'b0;
        do_reset(1'b0);
        tog_in = 1'b1;
        step();
        step();
        step();
        check("t3_valid1", 32'(evt_valid), 32'd1);
        check("t3_count1", 32'(evt_count), 32'd1);
        step();
        tog_in = 1'b0;
        step();
        step();
        check("t3_ovr_before", 32'(overrun), 32'd0);
        step();
        check("t3_ovr",    32'(overrun),   32'd1);
        check("t3_count2", 32'(evt_count), 32'd2);
        check("t3_hold",   32'(evt_valid), 32'd1);
        step();
        step();
        check("t3_hold2", 32'(evt_valid), 32'd1);
        evt_ready = 1'b1;
        step();
        ack_par = ~ack_par;
        check("t3_accept", 32'(evt_valid), 32'd0);
        check("t3_ack",    32'(tog_ack),   32'(ack_exp(ack_par)));
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_one_hs", 32'(evt_valid), 32'd0);
        end

        // Test 5: a new drop in the same cycle as clr_ovr keeps overrun set.
        evt_ready = 1'b0;
        tog_in    = 1'b1;
        step();
        step();
        step();
        check("t5_pend", 32'(evt_valid), 32'd1);
        step();
        tog_in = 1'b0;
        step();
        step();
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("t5_set_wins", 32'(overrun),   32'd1);
        check("t5_count",    32'(evt_count), 32'd4);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("t5_clr", 32'(overrun), 32'd0);

        // Test 6: reset while PEND clears everything, with no handshake after.
        tog_in = 1'b1;
        step();
        step();
        step();
        check("t6_ovr_pre",   32'(overrun),   32'd1);
        check("t6_valid_pre", 32'(evt_valid), 32'd1);
        rst = 1'b1;
        step();
        check("t6_valid", 32'(evt_valid), 32'd0);
        check("t6_count", 32'(evt_count), 32'd0);
        check("t6_ovr",   32'(overrun),   32'd0);
        check("t6_ack",   32'(tog_ack),   32'd0);
        rst       = 1'b0;
        evt_ready = 1'b1;
        ack_par   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t6_no_hs", 32'(evt_valid), 32'd0);
        end
        check("t6_ack_after", 32'(tog_ack), 32'(ack_exp(ack_par)));

        // Test 7: an accept in the same cycle as a new edge keeps PEND (no bubble).
        evt_ready = 1'b0;
        do_reset(1'b0);
        tog_in = 1'b1;
        step();
        step();
        step();
        step();
        tog_in = 1'b0;
        step();
        step();
        evt_ready = 1'b1;
        step();
        ack_par = ~ack_par;
        check("t7_b2b_valid", 32'(evt_valid), 32'd1);
        check("t7_b2b_ovr",   32'(overrun),   32'd0);
        check("t7_b2b_count", 32'(evt_count), 32'd2);
        check("t7_b2b_ack",   32'(tog_ack),   32'(ack_exp(ack_par)));
        step();
        ack_par = ~ack_par;
        check("t7_second", 32'(evt_valid), 32'd0);
        check("t7_ack2",   32'(tog_ack),   32'(ack_exp(ack_par)));

        // Test 4: 256 toggles, 2 cycles apart, with ready high. Each toggle
        // gives one handshake and the count wraps to 0.
        evt_ready = 1'b1;
        do_reset(1'b0);
        hs = 0;
        for (int i = 0; i < 256; i++) begin
            tog_in = ~tog_in;
            for (int j = 0; j < 2; j++) begin
                if (evt_valid && evt_ready) hs++;
                step();
            end
        end
        for (int j = 0; j < 6; j++) begin
            if (evt_valid && evt_ready) hs++;
            step();
        end
        check("t4_handshakes", 32'(hs),        32'd256);
        check("t4_wrap",       32'(evt_count), 32'd0);
        check("t4_ovr",        32'(overrun),   32'd0);
        check("t4_idle",       32'(evt_valid), 32'd0);
        check("t4_ack",        32'(tog_ack),   32'(ack_exp(1'b0)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
